sha256_msg_feeder: RTL and testbench

Front end of the SHA-256 datapath, sitting in front of `sha256_compressor`. It accepts a message as a byte stream and performs FIPS 180-4 padding. It splits the padded message into 512-bit blocks and drives each block into the compressor through its `start`/`done` handshake, chaining the intermediate hash from one block to the next. When the final block completes, it presents the 256-bit digest.

---
 rtl/sha256_msg_feeder.sv | 191 +++++++++++++++++++
 tb/tb_sha256_msg_feeder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_feeder.sv
// sha256_msg_feeder
//   Byte-stream front end for sha256_compressor. Collects message bytes into
//   512-bit blocks, appends the 0x80 marker, zero fill and 64-bit big-endian
//   bit length, and hands each block to the compressor over a start/done
//   handshake while chaining the intermediate hash between blocks.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_data/    message byte stream; in_last tags the final byte,
//   in_last/in_ready     a byte moves on in_valid & in_ready
//   comp_start           block request, held until comp_done is sampled
//   comp_message_block   block to compress (stable while comp_start)
//   comp_initial_hash    chaining value for the block (stable while comp_start)
//   comp_hash_out        compressor result, valid with comp_done
//   comp_done            compressor completion (pulse or level)
//   digest/digest_valid  final hash and its one-cycle update strobe
//   busy                 first accepted byte through digest_valid
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | accept message bytes into the block buffer
// PAD   | place 0x80 / zero fill / bit length into the buffer (1 cycle)
// SEND  | load compressor inputs, raise comp_start (waits out a stale done)
// WAIT  | hold comp_start until comp_done, capture the chaining value
// OUT   | publish digest, pulse digest_valid, clear per-message state
module sha256_msg_feeder #(
    parameter logic [255:0] H0 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         comp_start,
    output logic [511:0] comp_message_block,
    output logic [255:0] comp_initial_hash,
    input  logic [255:0] comp_hash_out,
    input  logic         comp_done,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_FILL,
        S_PAD,
        S_SEND,
        S_WAIT,
        S_OUT
    } state_t;

    state_t         state;
    logic [511:0]   blk;            // block buffer, byte 0 in bits [511:504]
    logic [6:0]     pos;            // next byte index, reaches 64 on a full block
    logic [63:0]    bitlen;
    logic           pad80_pending;  // 0x80 marker still has to be placed
    logic           len_pending;    // marker placed, length needs an extra block
    logic           blk_final;      // buffered block is the last of the message
    logic           first_blk;      // next block uses H0 as its chaining value
    logic [255:0]   chain;

    logic           accept;
    logic [8:0]     wr_lsb;
    logic [511:0]   pad_blk;
    logic           pad_final;

    assign accept = (state == S_FILL) && in_valid && in_ready;
    assign wr_lsb = 9'd504 - {pos[5:0], 3'b000};

    // Padded view of the buffer. The length field fits in this block when the
    // marker lands at byte 55 or earlier, or when the marker already went out
    // in the previous block (the buffer is then all zeros).
    always_comb begin
        pad_final = !pad80_pending || (pos <= 7'd55);
        pad_blk   = blk;
        for (int i = 0; i < 64; i++) begin
            if (pad80_pending) begin
                if (i == int'(pos)) begin
                    pad_blk[511 - 8*i -: 8] = 8'h80;
                end else if (i > int'(pos)) begin
                    pad_blk[511 - 8*i -: 8] = 8'h00;
                end
            end
        end
        if (pad_final) begin
            pad_blk[63:0] = bitlen;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_FILL;
            blk                <= '0;
            pos                <= '0;
            bitlen             <= '0;
            pad80_pending      <= 1'b0;
            len_pending        <= 1'b0;
            blk_final          <= 1'b0;
            first_blk          <= 1'b1;
            chain              <= '0;
            in_ready           <= 1'b0;
            comp_start         <= 1'b0;
            comp_message_block <= '0;
            comp_initial_hash  <= '0;
            digest             <= '0;
            digest_valid       <= 1'b0;
            busy               <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            case (state)
                S_FILL: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        blk[wr_lsb +: 8] <= in_data;
                        pos              <= pos + 7'd1;
                        bitlen           <= bitlen + 64'd8;
                        busy             <= 1'b1;
                        if (pos == 7'd63) begin
                            // full block; a final byte here defers the marker
                            state         <= S_SEND;
                            in_ready      <= 1'b0;
                            pad80_pending <= in_last;
                            blk_final     <= 1'b0;
                        end else if (in_last) begin
                            state         <= S_PAD;
                            in_ready      <= 1'b0;
                            pad80_pending <= 1'b1;
                        end
                    end
                end

                S_PAD: begin
                    blk           <= pad_blk;
                    pad80_pending <= 1'b0;
                    len_pending   <= !pad_final;
                    blk_final     <= pad_final;
                    state         <= S_SEND;
                end

                S_SEND: begin
                    // a level-style done from the previous block must drop
                    // before the next request goes out
                    if (!comp_done) begin
                        comp_message_block <= blk;
                        comp_initial_hash  <= first_blk ? H0 : chain;
                        comp_start         <= 1'b1;
                        state              <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (comp_done) begin
                        chain      <= comp_hash_out;
                        comp_start <= 1'b0;
                        pos        <= '0;
                        first_blk  <= 1'b0;
                        blk        <= '0;
                        if (blk_final) begin
                            state <= S_OUT;
                        end else if (pad80_pending || len_pending) begin
                            state <= S_PAD;
                        end else begin
                            state    <= S_FILL;
                            in_ready <= 1'b1;
                        end
                    end
                end

                S_OUT: begin
                    digest        <= chain;
                    digest_valid  <= 1'b1;
                    busy          <= 1'b0;
                    bitlen        <= '0;
                    pad80_pending <= 1'b0;
                    len_pending   <= 1'b0;
                    blk_final     <= 1'b0;
                    first_blk     <= 1'b1;
                    in_ready      <= 1'b1;
                    state         <= S_FILL;
                end

                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
`timescale 1ns/1ps
module tb_sha256_msg_feeder;

    localparam logic [255:0] H0 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         comp_start;
    logic [511:0] comp_message_block;
    logic [255:0] comp_initial_hash;
    logic [255:0] comp_hash_out;
    logic         comp_done;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;

    always #5 clk = ~clk;

    sha256_msg_feeder #(.H0(H0)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_last            (in_last),
        .in_ready           (in_ready),
        .comp_start         (comp_start),
        .comp_message_block (comp_message_block),
        .comp_initial_hash  (comp_initial_hash),
        .comp_hash_out      (comp_hash_out),
        .comp_done          (comp_done),
        .digest             (digest),
        .digest_valid       (digest_valid),
        .busy               (busy)
    );

    int compared   = 0;
    int mismatched = 0;
    int done_hold  = 1;

    logic [511:0] obs_blk [$];
    logic [255:0] obs_ih  [$];
    logic [7:0]   msg_q   [$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- SHA-256 compression reference ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] b);
        logic [31:0] w [64];
        logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        a = hin[255:224]; bb = hin[223:192]; c = hin[191:160]; d = hin[159:128];
        e = hin[127:96];  f = hin[95:64];    g = hin[63:32];   hh = hin[31:0];
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = bb; bb = a; a = t1 + t2;
        end
        return {a + hin[255:224], bb + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],    g + hin[63:32],   hh + hin[31:0]};
    endfunction

    // ---------------- compressor model ----------------
    // Latches each rising comp_start, answers after 1..4 cycles with a done
    // held for done_hold cycles. A request outstanding across a reset still
    // answers, which lands a stray done in FILL.
    initial begin : comp_model
        logic         prev_start;
        logic         pending;
        int           lat_cnt;
        int           hold_cnt;
        logic [255:0] res;
        prev_start = 1'b0; pending = 1'b0; lat_cnt = 0; hold_cnt = 0; res = '0;
        comp_done = 1'b0;
        comp_hash_out = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_start = 1'b0;
            end else begin
                if (comp_start && !prev_start) begin
                    obs_blk.push_back(comp_message_block);
                    obs_ih.push_back(comp_initial_hash);
                    res     = sha_compress(comp_initial_hash, comp_message_block);
                    pending = 1'b1;
                    lat_cnt = int'($urandom_range(4, 1));
                end
                prev_start = comp_start;
            end
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) comp_done = 1'b0;
            end else if (pending) begin
                if (lat_cnt > 0) begin
                    lat_cnt--;
                end else begin
                    comp_done     = 1'b1;
                    comp_hash_out = res;
                    hold_cnt      = done_hold;
                    pending       = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_msg(input bit gaps);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < msg_q.size() && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(99, 0) < 40) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = msg_q[idx];
                in_last  = (idx == msg_q.size() - 1);
            end
            if (in_valid && in_ready) idx++;
        end
        chk("send_complete", 1'(idx == msg_q.size()), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_msg(input string tag, input bit gaps, input int hold, input bit chk_lat);
        logic [7:0]   pad [$];
        logic [511:0] exp_blk [$];
        logic [255:0] exp_ih [$];
        logic [511:0] bv;
        logic [255:0] h;
        logic [63:0]  bl;
        int           n;
        bit           seen, bad_rdy, bad_busy;

        done_hold = hold;
        obs_blk.delete();
        obs_ih.delete();

        n = msg_q.size();
        pad = msg_q;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bl = 64'(n) * 64'd8;
        for (int k = 0; k < 8; k++) pad.push_back(bl[63 - 8*k -: 8]);
        h = H0;
        for (int b = 0; b < pad.size() / 64; b++) begin
            bv = '0;
            for (int j = 0; j < 64; j++) bv[511 - 8*j -: 8] = pad[64*b + j];
            exp_blk.push_back(bv);
            exp_ih.push_back(h);
            h = sha_compress(h, bv);
        end

        send_msg(gaps);

        if (chk_lat) begin
            chk({tag, " start_lat0"}, comp_start, 1'b0);
            chk({tag, " ready_after_last"}, in_ready, 1'b0);
            if (n % 64 != 0) begin
                @(negedge clk);
                chk({tag, " start_lat1"}, comp_start, 1'b0);
            end
            @(negedge clk);
            chk({tag, " start_rise"}, comp_start, 1'b1);
        end

        seen = 0; bad_rdy = 0; bad_busy = 0;
        for (int g = 0; g < 4000 && !seen; g++) begin
            @(negedge clk);
            if (digest_valid) seen = 1;
            else begin
                if (in_ready) bad_rdy = 1;
                if (!busy) bad_busy = 1;
            end
        end
        chk({tag, " digest_valid_seen"}, seen, 1'b1);
        chk({tag, " digest"}, digest, h);
        chk({tag, " busy_at_digest"}, busy, 1'b0);
        chk({tag, " ready_low_until_digest"}, bad_rdy, 1'b0);
        chk({tag, " busy_high_until_digest"}, bad_busy, 1'b0);
        chk({tag, " start_count"}, 32'(obs_blk.size()), 32'(exp_blk.size()));
        for (int b = 0; b < exp_blk.size() && b < obs_blk.size(); b++) begin
            chk($sformatf("%s blk%0d", tag, b), obs_blk[b], exp_blk[b]);
            chk($sformatf("%s ih%0d", tag, b), obs_ih[b], exp_ih[b]);
        end
        @(negedge clk);
        chk({tag, " digest_valid_pulse"}, digest_valid, 1'b0);
        chk({tag, " digest_held"}, digest, h);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  len;
        bit  seen;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst in_ready", in_ready, 1'b0);
        chk("rst comp_start", comp_start, 1'b0);
        chk("rst block", comp_message_block, '0);
        chk("rst ih", comp_initial_hash, '0);
        chk("rst digest", digest, '0);
        chk("rst digest_valid", digest_valid, 1'b0);
        chk("rst busy", busy, 1'b0);
        rst = 1'b0;
        chk("ready before first edge", in_ready, 1'b0);
        @(negedge clk);
        chk("ready after first edge", in_ready, 1'b1);

        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("abc", 0, 1, 1);
        chk("abc known digest", digest, ABC_DIGEST);

        msg_q.delete(); repeat (55) msg_q.push_back(8'h41);
        run_msg("a55", 0, 1, 0);

        msg_q.delete(); repeat (56) msg_q.push_back(8'h41);
        run_msg("a56", 0, 1, 0);

        msg_q.delete(); repeat (64) msg_q.push_back(8'($urandom));
        run_msg("r64", 0, 1, 1);

        msg_q.delete(); repeat (56) msg_q.push_back(8'h41);
        run_msg("a56 backpressure", 1, 3, 0);

        msg_q.delete(); repeat (64) msg_q.push_back(8'($urandom));
        run_msg("r64 backpressure", 1, 3, 0);

        for (int m = 0; m < 5; m++) begin
            len = int'($urandom_range(150, 1));
            msg_q.delete();
            repeat (len) msg_q.push_back(8'($urandom));
            run_msg($sformatf("rand%0d len%0d", m, len), 1'($urandom), ($urandom_range(1, 0) != 0) ? 3 : 1, 0);
        end

        // reset while block 1 of a two-block message is in flight
        done_hold = 1;
        msg_q.delete(); repeat (56) msg_q.push_back(8'h41);
        send_msg(0);
        seen = 0;
        for (int g = 0; g < 200 && !seen; g++) begin
            @(negedge clk);
            if (comp_start) seen = 1;
        end
        chk("mid reset reached wait", seen, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid rst in_ready", in_ready, 1'b0);
        chk("mid rst comp_start", comp_start, 1'b0);
        chk("mid rst block", comp_message_block, '0);
        chk("mid rst ih", comp_initial_hash, '0);
        chk("mid rst digest", digest, '0);
        chk("mid rst digest_valid", digest_valid, 1'b0);
        chk("mid rst busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid rst ready next edge", in_ready, 1'b1);
        repeat (8) @(negedge clk);
        chk("stray done start", comp_start, 1'b0);
        chk("stray done busy", busy, 1'b0);
        chk("stray done ready", in_ready, 1'b1);
        chk("stray done digest", digest, '0);

        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("abc after reset", 0, 3, 1);
        chk("abc after reset known digest", digest, ABC_DIGEST);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
